// File: rtl/div_hilo.sv
// Iterative radix-2 restoring divider producing {remainder, quotient} for the HI/LO pair.
// Optional macro DIV_FAST_ZERO_EN: a zero dividend with a non-zero divisor finishes in one cycle.
`timescale 1ns/1ps
module div_hilo #(
    parameter int WIDTH = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               signed_div_i,
    input  logic [WIDTH-1:0]   opdata1_i,
    input  logic [WIDTH-1:0]   opdata2_i,
    input  logic               start_i,
    input  logic               annul_i,
    output logic [2*WIDTH-1:0] result_o,
    output logic               ready_o
);

    localparam int CW = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {IDLE, DIVZERO, ON, END} state_t;

    state_t               state_q, state_n;
    logic [CW-1:0]        cnt_q, cnt_n;
    logic [WIDTH-1:0]     rem_q, rem_n;
    logic [WIDTH-1:0]     quo_q, quo_n;
    logic [WIDTH-1:0]     dsr_q, dsr_n;
    logic                 qneg_q, qneg_n;
    logic                 rneg_q, rneg_n;
    logic [2*WIDTH-1:0]   result_n;
    logic                 ready_n;
    logic [WIDTH:0]       sh, diff;
    logic [WIDTH-1:0]     step_rem, step_quo;

    function automatic logic [WIDTH-1:0] neg(input logic [WIDTH-1:0] v);
        return ~v + {{(WIDTH-1){1'b0}}, 1'b1};
    endfunction

    // Magnitude of an operand; the most negative value wraps to itself, which is the correct unsigned magnitude.
    function automatic logic [WIDTH-1:0] mag(input logic signed [WIDTH-1:0] v, input logic sg);
        return (sg && (v < 0)) ? neg(v) : v;
    endfunction

    function automatic logic [WIDTH-1:0] fixup(input logic [WIDTH-1:0] v, input logic sg);
        return sg ? neg(v) : v;
    endfunction

    always_comb begin
        state_n  = state_q;
        cnt_n    = cnt_q;
        rem_n    = rem_q;
        quo_n    = quo_q;
        dsr_n    = dsr_q;
        qneg_n   = qneg_q;
        rneg_n   = rneg_q;
        result_n = result_o;

        // One restoring step: the top bit of the trial difference is the borrow.
        sh       = {rem_q, quo_q[WIDTH-1]};
        diff     = sh - {1'b0, dsr_q};
        step_rem = diff[WIDTH] ? sh[WIDTH-1:0] : diff[WIDTH-1:0];
        step_quo = {quo_q[WIDTH-2:0], ~diff[WIDTH]};

        case (state_q)
            IDLE: begin
                if (start_i && !annul_i) begin
                    cnt_n  = '0;
                    rem_n  = '0;
                    qneg_n = signed_div_i & (opdata1_i[WIDTH-1] ^ opdata2_i[WIDTH-1]);
                    rneg_n = signed_div_i & opdata1_i[WIDTH-1];
                    dsr_n  = mag(opdata2_i, signed_div_i);
                    quo_n  = mag(opdata1_i, signed_div_i);
                    if (opdata2_i == '0) begin
                        quo_n   = opdata1_i;
                        state_n = DIVZERO;
                    end
`ifdef DIV_FAST_ZERO_EN
                    else if (opdata1_i == '0) begin
                        result_n = '0;
                        state_n  = END;
                    end
`endif
                    else begin
                        state_n = ON;
                    end
                end
            end
            DIVZERO: begin
                if (annul_i) begin
                    state_n = IDLE;
                end else begin
                    result_n = {quo_q, {WIDTH{1'b1}}};
                    state_n  = END;
                end
            end
            ON: begin
                if (annul_i) begin
                    state_n = IDLE;
                end else begin
                    rem_n = step_rem;
                    quo_n = step_quo;
                    cnt_n = cnt_q + 1'b1;
                    if (cnt_q == CW'(WIDTH - 1)) begin
                        result_n = {fixup(step_rem, rneg_q), fixup(step_quo, qneg_q)};
                        state_n  = END;
                    end
                end
            end
            END: begin
                if (!start_i) state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase

        ready_n = (state_n == END);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            result_o <= '0;
            ready_o  <= 1'b0;
        end else begin
            state_q  <= state_n;
            cnt_q    <= cnt_n;
            result_o <= result_n;
            ready_o  <= ready_n;
        end
    end

    always_ff @(posedge clk) begin
        rem_q  <= rem_n;
        quo_q  <= quo_n;
        dsr_q  <= dsr_n;
        qneg_q <= qneg_n;
        rneg_q <= rneg_n;
    end

endmodule

// File: tb/tb_div_hilo.sv
// Self-checking bench for div_hilo: directed cases plus randomized operations against an arithmetic model.
`timescale 1ns/1ps
module tb_div_hilo;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        signed_div_i = 1'b0;
    logic [31:0] opdata1_i = '0;
    logic [31:0] opdata2_i = '0;
    logic        start_i = 1'b0;
    logic        annul_i = 1'b0;
    logic [63:0] result_o;
    logic        ready_o;

    int errors = 0;
    int checks = 0;
    logic [63:0] last_exp = '0;

    always #5 clk = ~clk;

    div_hilo #(.WIDTH(32)) dut (
        .clk(clk), .rst(rst), .signed_div_i(signed_div_i),
        .opdata1_i(opdata1_i), .opdata2_i(opdata2_i),
        .start_i(start_i), .annul_i(annul_i),
        .result_o(result_o), .ready_o(ready_o)
    );

    function automatic logic [63:0] ref_div(input logic [31:0] a, input logic [31:0] b, input logic sg);
        longint sa, sb, q, r;
        if (b == 32'd0) return {a, 32'hFFFF_FFFF};
        if (sg) begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
            q  = sa / sb;
            r  = sa % sb;
            return {r[31:0], q[31:0]};
        end
        return {a % b, a / b};
    endfunction

    // Edges after the sampling edge until ready_o is seen.
    function automatic int ref_lat(input logic [31:0] a, input logic [31:0] b);
        if (b == 32'd0) return 1;
`ifdef DIV_FAST_ZERO_EN
        if (a == 32'd0) return 0;
`endif
        return 32;
    endfunction

    // Issues an operation and waits for ready_o; start_i is left high on return.
    task automatic do_div(input logic [31:0] a, input logic [31:0] b, input logic sg,
                          output int lat, output logic [63:0] res);
        @(negedge clk);
        opdata1_i = a; opdata2_i = b; signed_div_i = sg; start_i = 1'b1;
        @(posedge clk); #1;
        lat = 0;
        while (!ready_o && lat < 100) begin
            opdata1_i = $urandom; opdata2_i = $urandom; signed_div_i = 1'($urandom);
            @(posedge clk); #1;
            lat++;
        end
        res = result_o;
    endtask

    task automatic finish_op(output logic rdy, output logic [63:0] res);
        @(negedge clk);
        start_i = 1'b0;
        @(posedge clk); #1;
        rdy = ready_o;
        res = result_o;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (ready_o !== 1'b0) begin errors++; $display("FAIL reset_ready got=%b exp=0", ready_o); end
        checks++;
        if (result_o !== 64'd0) begin errors++; $display("FAIL reset_result got=%h exp=0", result_o); end
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic test_hold_and_drop();
        int lat; logic [63:0] res, exp_r, r2; logic rdy;
        exp_r = ref_div(32'd100, 32'd7, 1'b0);
        do_div(32'd100, 32'd7, 1'b0, lat, res);
        checks++;
        if (lat !== 32) begin errors++; $display("FAIL u100_7_latency got=%0d exp=32", lat); end
        checks++;
        if (res !== 64'h0000_0002_0000_000E) begin errors++; $display("FAIL u100_7_result got=%h exp=%h", res, 64'h0000_0002_0000_000E); end
        for (int i = 0; i < 3; i++) begin
            annul_i = (i == 1);
            @(posedge clk); #1;
            checks++;
            if (ready_o !== 1'b1 || result_o !== exp_r) begin
                errors++; $display("FAIL end_hold_%0d got=%b/%h exp=1/%h", i, ready_o, result_o, exp_r);
            end
        end
        annul_i = 1'b0;
        finish_op(rdy, r2);
        checks++;
        if (rdy !== 1'b0) begin errors++; $display("FAIL drop_ready got=%b exp=0", rdy); end
        checks++;
        if (r2 !== exp_r) begin errors++; $display("FAIL drop_result_hold got=%h exp=%h", r2, exp_r); end
        last_exp = exp_r;
    endtask

    task automatic test_directed();
        logic [31:0] a_t [5] = '{32'hFFFF_FFF9, 32'hFFFF_FFF9, 32'h1234_5678, 32'h8000_0000, 32'd0};
        logic [31:0] b_t [5] = '{32'd2,        32'd2,        32'd0,        32'hFFFF_FFFF, 32'd5};
        logic        s_t [5] = '{1'b1,         1'b0,         1'b0,         1'b1,          1'b0};
        logic [63:0] e_t [5] = '{64'hFFFF_FFFF_FFFF_FFFD, 64'h0000_0001_7FFF_FFFC,
                                 64'h1234_5678_FFFF_FFFF, 64'h0000_0000_8000_0000, 64'd0};
        int lat; logic [63:0] res, r2; logic rdy;
        for (int i = 0; i < 5; i++) begin
            do_div(a_t[i], b_t[i], s_t[i], lat, res);
            checks++;
            if (lat !== ref_lat(a_t[i], b_t[i])) begin
                errors++; $display("FAIL directed_%0d_latency got=%0d exp=%0d", i, lat, ref_lat(a_t[i], b_t[i]));
            end
            checks++;
            if (res !== e_t[i]) begin errors++; $display("FAIL directed_%0d_result got=%h exp=%h", i, res, e_t[i]); end
            finish_op(rdy, r2);
            checks++;
            if (rdy !== 1'b0) begin errors++; $display("FAIL directed_%0d_drop got=%b exp=0", i, rdy); end
            last_exp = e_t[i];
        end
    endtask

    task automatic test_annul_and_reset();
        int lat; logic [63:0] res, r2; logic rdy, bad;
        for (int pass = 0; pass < 2; pass++) begin
            @(negedge clk);
            opdata1_i = 32'd100; opdata2_i = 32'd7; signed_div_i = 1'b0; start_i = 1'b1;
            @(posedge clk);
            repeat (9) @(posedge clk);
            @(negedge clk);
            start_i = 1'b0;
            if (pass == 0) annul_i = 1'b1; else rst = 1'b0;
            @(posedge clk); #1;
            if (pass == 1) last_exp = 64'd0;
            checks++;
            if (ready_o !== 1'b0 || result_o !== last_exp) begin
                errors++; $display("FAIL abort_%0d_now got=%b/%h exp=0/%h", pass, ready_o, result_o, last_exp);
            end
            @(negedge clk);
            annul_i = 1'b0; rst = 1'b1;
            bad = 1'b0;
            repeat (40) begin
                @(posedge clk); #1;
                if (ready_o !== 1'b0 || result_o !== last_exp) bad = 1'b1;
            end
            checks++;
            if (bad !== 1'b0) begin errors++; $display("FAIL abort_%0d_quiet got=%b exp=0", pass, bad); end
            do_div(32'd9, 32'd3, 1'b0, lat, res);
            checks++;
            if (lat !== 32 || res !== 64'h0000_0000_0000_0003) begin
                errors++; $display("FAIL abort_%0d_next got=%0d/%h exp=32/%h", pass, lat, res, 64'h3);
            end
            finish_op(rdy, r2);
            last_exp = 64'h3;
        end
    endtask

    task automatic test_annul_in_idle();
        int lat; logic bad; logic [63:0] r2; logic rdy;
        @(negedge clk);
        opdata1_i = 32'd50; opdata2_i = 32'd6; signed_div_i = 1'b0; start_i = 1'b1; annul_i = 1'b1;
        bad = 1'b0;
        repeat (40) begin
            @(posedge clk); #1;
            if (ready_o !== 1'b0) bad = 1'b1;
        end
        checks++;
        if (bad !== 1'b0) begin errors++; $display("FAIL idle_annul_blocks got=%b exp=0", bad); end
        @(negedge clk);
        annul_i = 1'b0;
        @(posedge clk); #1;
        lat = 0;
        while (!ready_o && lat < 100) begin @(posedge clk); #1; lat++; end
        checks++;
        if (lat !== 32 || result_o !== 64'h0000_0002_0000_0008) begin
            errors++; $display("FAIL idle_annul_release got=%0d/%h exp=32/%h", lat, result_o, 64'h0000_0002_0000_0008);
        end
        finish_op(rdy, r2);
    endtask

    task automatic test_random();
        logic [31:0] a, b; logic sg; int lat; logic [63:0] res, r2, e; logic rdy;
        for (int i = 0; i < 25; i++) begin
            a  = $urandom;
            b  = $urandom;
            sg = 1'($urandom);
            case ($urandom_range(0, 7))
                0: b = 32'd0;
                1: a = 32'd0;
                2: b = 32'($urandom_range(1, 15));
                3: begin a = 32'h8000_0000; b = ($urandom_range(0, 1) == 0) ? 32'hFFFF_FFFF : 32'd1; end
                4: b = {1'b1, b[30:0]};
                default: ;
            endcase
            e = ref_div(a, b, sg);
            do_div(a, b, sg, lat, res);
            checks++;
            if (lat !== ref_lat(a, b)) begin
                errors++; $display("FAIL rand_%0d_latency a=%h b=%h s=%b got=%0d exp=%0d", i, a, b, sg, lat, ref_lat(a, b));
            end
            checks++;
            if (res !== e) begin
                errors++; $display("FAIL rand_%0d_result a=%h b=%h s=%b got=%h exp=%h", i, a, b, sg, res, e);
            end
            finish_op(rdy, r2);
            checks++;
            if (rdy !== 1'b0 || r2 !== e) begin
                errors++; $display("FAIL rand_%0d_drop got=%b/%h exp=0/%h", i, rdy, r2, e);
            end
        end
    endtask

    initial begin
        test_reset();
        test_hold_and_drop();
        test_directed();
        test_annul_and_reset();
        test_annul_in_idle();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/div_hilo.md
Name: div_hilo

Overview:
- Iterative 32-bit radix-2 restoring divider; executes DIV/DIVU and produces the value written into the HI/LO register pair.
- Sits beside the EX stage. The pipeline stalls while the divider is busy. On completion, result is {remainder, quotient}; the upper half goes to HI and the lower half to LO.
- Multi-cycle, with a start/ready handshake and annul on pipeline flush.

Parameters:
- WIDTH, 32, operand width in bits. The iteration count equals WIDTH. The counter is clog2(WIDTH)+1 bits wide.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, synchronous, active-low. rst==0 at a rising edge resets the block.
- signed_div_i  in  1  1 = DIV (two's complement), 0 = DIVU.
- opdata1_i  in  WIDTH  dividend.
- opdata2_i  in  WIDTH  divisor.
- start_i  in  1  request. Held high by EX until ready_o is seen.
- annul_i  in  1  flush. Aborts the operation in flight.
- result_o  out  2*WIDTH  {remainder, quotient}, i.e. {HI, LO}.
- ready_o  out  1  result_o valid.

Behaviour:
- Reset: state=IDLE, result_o=0, ready_o=0, counter=0. Reset is sampled only at the clock edge. Reset mid-operation discards all work, and the next cycle is IDLE.
- States: IDLE, DIVZERO, ON, END.
- IDLE:
  - start_i=1 and annul_i=0 at edge T: latch the operands.
  - Divisor==0: go to DIVZERO.
  - Otherwise: go to ON with counter=0.
  - All other cases: stay in IDLE, ready_o=0.
- Operand preparation (at latch):
  - Signed mode: a negative operand is replaced by its two's-complement magnitude.
  - Record the sign of the quotient, sign1^sign2, and the sign of the remainder, sign1.
  - Unsigned mode: no negation; both signs are 0.
- ON, one restoring step per cycle:
  - Shift {partial remainder, dividend} left 1.
  - Trial-subtract the divisor.
  - If the result is non-negative, keep the difference and shift in quotient bit 1; otherwise restore and shift in 0.
  - After the 32nd step (counter==WIDTH), go to END.
- Fix-up at the ON→END transition: negate the quotient if its sign is 1; negate the remainder if its sign is 1. Register result_o.
- Latency: start sampled at T gives state ON during T+1..T+32, and END with ready_o=1 at T+33.
- DIVZERO: result_o = {opdata1 latched, {WIDTH{1'b1}}}. Go to END, so ready_o=1 at T+2. This is the team's decided value for the architecturally undefined case.
- END:
  - ready_o=1 and result_o is held stable.
  - start_i=0: go to IDLE. ready_o falls the next cycle; result_o holds its last value.
  - start_i=1: stay in END. No restart occurs without start_i first being deasserted.
- annul_i=1 in ON or DIVZERO: go to IDLE next cycle. ready_o stays 0 and result_o is unchanged.
- annul_i in IDLE blocks acceptance.
- annul_i in END is ignored; the result has already been produced.
- Operand inputs are ignored after latch. Changes during ON have no effect.
- Overflow case: signed 0x80000000 / 0xFFFFFFFF gives quotient 0x80000000, remainder 0. This is the natural wrap, with no trap.
- result_o and ready_o are pure register outputs, with no combinational input-to-output path.

Optional Feature:
- Macro DIV_FAST_ZERO_EN.
- Defined: in IDLE, a start with dividend==0 and divisor!=0 goes directly to END with result_o=0 and ready_o=1 at T+1. Divisor==0 still takes precedence, via DIVZERO.
- Undefined: a zero dividend takes the full 32-step path, with ready_o at T+33 and result 0.

Test Plan:
- Unsigned 100/7: start at T → ready_o=1 at T+33, result_o={0x00000002, 0x0000000E}. Hold start_i for 3 extra cycles → remains in END with result_o stable. Drop start_i → ready_o=0 the next cycle.
- Signed -7/2 (0xFFFFFFF9/0x00000002) → result_o={0xFFFFFFFF, 0xFFFFFFFD}. Unsigned with the same operands → {0x00000001, 0x7FFFFFFC}.
- Divide by zero, 0x12345678/0 → ready_o=1 at T+2, result_o={0x12345678, 0xFFFFFFFF}.
- Signed 0x80000000/0xFFFFFFFF → {0x00000000, 0x80000000} at T+33.
- Start 100/7, annul_i=1 at T+10 → IDLE at T+11 and ready_o never asserts. Then a new start 9/3 → {0, 3} after 33 cycles. Repeat the sequence with rst=0 at T+10 instead of annul: same abort, and result_o=0.
- Start 0/5 → with DIV_FAST_ZERO_EN, ready_o at T+1 with result 0; without it, ready_o at T+33 with result 0.
